muovi_quadrato: RTL and testbench
=================================

# muovi_quadrato

Per-frame position controller for the on-screen square. Once per video frame it samples four direction buttons, or runs an autonomous bounce, and computes the square's centre. It drives X_POS/Y_POS directly into the square/frame hit-test stage. Outputs change only in the two cycles after the frame tick, so they stay stable for the whole active picture. X wraps modulo the horizontal resolution, matching the hit-test's wrap handling; Y is clamped or bounced so the square never leaves the screen vertically.

## Interface
- H, 1280: horizontal resolution; X range 0..H-1
- V, 1024: vertical resolution; Y range 0..V-1
- ALTEZZA, 100: square height; Y limits are YMIN=ALTEZZA/2 and YMAX=V-1-ALTEZZA/2 (50..973 at defaults)
- PASSO, 4: pixels moved per frame per axis; must satisfy 1 ≤ PASSO < H
- X_INIT, 640: X reset value
- Y_INIT, 512: Y reset value; must lie in YMIN..YMAX

Ports:
- CLOCK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- FRAME_TICK  in  1  one-cycle pulse at start of vertical blanking, synchronous to CLOCK
- SU, GIU, SINISTRA, DESTRA  in  1 each  raw button levels (up, down, left, right), asynchronous
- AUTO  in  1  1 = autonomous bounce, 0 = manual; asynchronous
- X_POS  out  11  square centre X
- Y_POS  out  11  square centre Y
- POS_AGG  out  1  one-cycle pulse when X_POS/Y_POS have just been updated

## Operation
- SU, GIU, SINISTRA, DESTRA and AUTO each pass through a 2-flop synchronizer. Only synchronized values are used.
- FSM states:
  - ATTESA: wait for FRAME_TICK. On FRAME_TICK, latch the synchronized inputs, then go to CALCOLO.
  - CALCOLO: compute the next X/Y into shadow registers, then go to PUBBLICA.
  - PUBBLICA: copy the shadow registers to X_POS/Y_POS and assert POS_AGG, then go to ATTESA.
- FRAME_TICK is ignored in CALCOLO and PUBBLICA.
- Arithmetic uses 12-bit internal values; results are truncated to 11 bits only after the range check.
- Manual mode, X:
  - DESTRA alone: X' = X+PASSO; if X' ≥ H then X' −= H.
  - SINISTRA alone: if X < PASSO then X' = X+H−PASSO, else X' = X−PASSO.
  - Both or neither: X unchanged.
- Manual mode, Y:
  - GIU alone: Y' = min(Y+PASSO, YMAX).
  - SU alone: Y' = max(Y−PASSO, YMIN).
  - Both or neither: Y unchanged.
- Auto mode: buttons are ignored. Internal direction flags DIR_X and DIR_Y apply (1 = right/down).
  - X moves by PASSO in direction DIR_X with the same wrap rule as manual mode. DIR_X never changes.
  - Y moves by PASSO in direction DIR_Y. If the result would pass YMAX, set Y' = YMAX and DIR_Y = 0. If it would pass YMIN, set Y' = YMIN and DIR_Y = 1.
- Switching AUTO takes effect at the next latched tick. Positions are kept; DIR flags keep their last values.

## Timing
- Reset values (asynchronous): X_POS=X_INIT, Y_POS=Y_INIT, POS_AGG=0, DIR_X=1, DIR_Y=1, FSM=ATTESA, synchronizers and shadow registers cleared.
- A button must be stable for ≥2 cycles before FRAME_TICK to be seen by that tick.
- FRAME_TICK high in cycle n (in ATTESA) gives:
  - CALCOLO in n+1;
  - X_POS/Y_POS updated and POS_AGG=1 in n+2;
  - ATTESA in n+3, with POS_AGG back to 0.
- X_POS/Y_POS are constant at all other times.
- Reset asserted in CALCOLO or PUBBLICA aborts the update. Outputs return to reset values and no POS_AGG is issued.
- Throughput: one update per FRAME_TICK. Ticks at most one every 3 cycles are all honoured.

## Test plan
- Reset: deassert RESET_N with defaults → X_POS=640, Y_POS=512, POS_AGG=0. Pulse RESET_N low mid-cycle → outputs return to these values immediately, without a clock edge.
- Manual right: hold DESTRA, pulse FRAME_TICK at cycle n → X_POS goes 640→644 at n+2, POS_AGG high only at n+2, Y_POS stays 512. DESTRA+SINISTRA held → no X change.
- Wrap: instance with X_INIT=1278, DESTRA, tick → X_POS=2. Then SINISTRA, tick → X_POS=1278.
- Clamp: instance with Y_INIT=52, SU, tick → Y_POS=50. SU, tick again → 50, and POS_AGG still pulses.
- Auto bounce: instance with Y_INIT=971, AUTO=1, tick → Y_POS=973, X_POS=644. Next tick → Y_POS=969. Buttons toggled meanwhile have no effect.
- Tick collisions: FRAME_TICK at n and n+1 → exactly one update, at n+2. RESET_N low at n+1 → no POS_AGG, outputs at init values.

Source files
------------

// File: rtl/muovi_quadrato.sv
// Per-frame position controller for the on-screen square: samples the direction
// buttons (or runs an autonomous bounce) once per FRAME_TICK and publishes the centre.
module muovi_quadrato #(
  parameter int H       = 1280,
  parameter int V       = 1024,
  parameter int ALTEZZA = 100,
  parameter int PASSO   = 4,
  parameter int X_INIT  = 640,
  parameter int Y_INIT  = 512
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        FRAME_TICK,
  input  logic        SU,
  input  logic        GIU,
  input  logic        SINISTRA,
  input  logic        DESTRA,
  input  logic        AUTO,
  output logic [10:0] X_POS,
  output logic [10:0] Y_POS,
  output logic        POS_AGG
);

  localparam logic [11:0] H_W     = 12'(H);
  localparam logic [11:0] PASSO_W = 12'(PASSO);
  localparam logic [11:0] YMIN_W  = 12'(ALTEZZA / 2);
  localparam logic [11:0] YMAX_W  = 12'(V - 1 - ALTEZZA / 2);
  localparam logic [10:0] X_RST   = 11'(X_INIT);
  localparam logic [10:0] Y_RST   = 11'(Y_INIT);

  typedef enum logic [1:0] {
    ATTESA,
    CALCOLO,
    PUBBLICA
  } state_t;

  state_t      state_reg;
  logic [4:0]  raw_in;
  logic [4:0]  sync1_reg;
  logic [4:0]  sync2_reg;
  logic [4:0]  lat_reg;
  logic [10:0] x_shadow_reg;
  logic [10:0] y_shadow_reg;
  logic        dir_x_reg;
  logic        dir_y_reg;

  logic        lat_su;
  logic        lat_giu;
  logic        lat_sinistra;
  logic        lat_destra;
  logic        lat_auto;

  logic [11:0] x_cur;
  logic [11:0] y_cur;
  logic [11:0] x_sum;
  logic [11:0] x_fwd;
  logic [11:0] x_bwd;
  logic [11:0] y_sum;
  logic        y_over;
  logic [11:0] y_inc;
  logic        y_under;
  logic [11:0] y_dec;
  logic [11:0] x_next;
  logic [11:0] y_next;
  logic        dir_y_next;

  // Bit order shared by the synchronizer and the latched copy.
  assign raw_in = {AUTO, DESTRA, SINISTRA, GIU, SU};

  assign lat_su       = lat_reg[0];
  assign lat_giu      = lat_reg[1];
  assign lat_sinistra = lat_reg[2];
  assign lat_destra   = lat_reg[3];
  assign lat_auto     = lat_reg[4];

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  // All candidate moves are formed at 12 bits so wrap and clamp tests see the carry.
  assign x_cur   = {1'b0, X_POS};
  assign y_cur   = {1'b0, Y_POS};
  assign x_sum   = x_cur + PASSO_W;
  assign x_fwd   = (x_sum >= H_W) ? (x_sum - H_W) : x_sum;
  assign x_bwd   = (x_cur < PASSO_W) ? (x_cur + H_W - PASSO_W) : (x_cur - PASSO_W);
  assign y_sum   = y_cur + PASSO_W;
  assign y_over  = (y_sum > YMAX_W);
  assign y_inc   = y_over ? YMAX_W : y_sum;
  assign y_under = (y_cur < (YMIN_W + PASSO_W));
  assign y_dec   = y_under ? YMIN_W : (y_cur - PASSO_W);

  always_comb begin
    x_next     = x_cur;
    y_next     = y_cur;
    dir_y_next = dir_y_reg;
    if (lat_auto) begin
      x_next = dir_x_reg ? x_fwd : x_bwd;
      if (dir_y_reg) begin
        y_next = y_inc;
        if (y_over) begin
          dir_y_next = 1'b0;
        end
      end else begin
        y_next = y_dec;
        if (y_under) begin
          dir_y_next = 1'b1;
        end
      end
    end else begin
      if (lat_destra && !lat_sinistra) begin
        x_next = x_fwd;
      end else if (lat_sinistra && !lat_destra) begin
        x_next = x_bwd;
      end
      if (lat_giu && !lat_su) begin
        y_next = y_inc;
      end else if (lat_su && !lat_giu) begin
        y_next = y_dec;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= ATTESA;
      lat_reg      <= '0;
      x_shadow_reg <= '0;
      y_shadow_reg <= '0;
      dir_x_reg    <= 1'b1;
      dir_y_reg    <= 1'b1;
      X_POS        <= X_RST;
      Y_POS        <= Y_RST;
      POS_AGG      <= 1'b0;
    end else begin
      case (state_reg)
        ATTESA: begin
          POS_AGG <= 1'b0;
          if (FRAME_TICK) begin
            lat_reg   <= sync2_reg;
            state_reg <= CALCOLO;
          end
        end
        CALCOLO: begin
          x_shadow_reg <= 11'(x_next);
          y_shadow_reg <= 11'(y_next);
          dir_y_reg    <= dir_y_next;
          // Outputs load on the same edge as the shadow so the new position is
          // already visible while PUBBLICA is asserting POS_AGG.
          X_POS        <= 11'(x_next);
          Y_POS        <= 11'(y_next);
          POS_AGG      <= 1'b1;
          state_reg    <= PUBBLICA;
        end
        PUBBLICA: begin
          X_POS     <= x_shadow_reg;
          Y_POS     <= y_shadow_reg;
          POS_AGG   <= 1'b0;
          state_reg <= ATTESA;
        end
        default: begin
          POS_AGG   <= 1'b0;
          state_reg <= ATTESA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muovi_quadrato.sv
// Bench for muovi_quadrato: four instances (default, X wrap, Y clamp, auto bounce)
// driven from a vector table, with a scoreboard checking every published position.
module tb_muovi_quadrato;

  typedef struct {
    int         inst;
    logic [4:0] inv;   // {AUTO, DESTRA, SINISTRA, GIU, SU}
    int         ex;
    int         ey;
  } vec_t;

  typedef struct {
    int inst;
    int ex;
    int ey;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [4:0]  in_v    [4];
  logic [10:0] x_pos   [4];
  logic [10:0] y_pos   [4];
  logic        pos_agg [4];

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[18];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    muovi_quadrato #(
      .X_INIT(gi == 1 ? 1278 : 640),
      .Y_INIT(gi == 2 ? 52 : (gi == 3 ? 971 : 512))
    ) u_dut (
      .CLOCK     (clk),
      .RESET_N   (rst_n),
      .FRAME_TICK(frame_tick),
      .SU        (in_v[gi][0]),
      .GIU       (in_v[gi][1]),
      .SINISTRA  (in_v[gi][2]),
      .DESTRA    (in_v[gi][3]),
      .AUTO      (in_v[gi][4]),
      .X_POS     (x_pos[gi]),
      .Y_POS     (y_pos[gi]),
      .POS_AGG   (pos_agg[gi])
    );
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: pop the oldest expectation when its instance publishes.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pos_agg[i] && exp_q.size() > 0 && exp_q[0].inst == i) begin
        mon_e = exp_q.pop_front();
        $display("txn inst=%0d x=%0d y=%0d exp_x=%0d exp_y=%0d",
                 i, x_pos[i], y_pos[i], mon_e.ex, mon_e.ey);
        check("sb_x", int'(x_pos[i]), mon_e.ex);
        check("sb_y", int'(y_pos[i]), mon_e.ey);
      end
    end
  end

  task automatic do_tick(input int inst, input logic [4:0] inv, input int ex, input int ey);
    int   x0;
    exp_t e;
    in_v[inst] = inv;
    repeat (3) @(negedge clk);
    x0 = int'(x_pos[inst]);
    e.inst = inst;
    e.ex   = ex;
    e.ey   = ey;
    exp_q.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("agg_n1", int'(pos_agg[inst]), 0);
    check("x_stable_n1", int'(x_pos[inst]), x0);
    @(negedge clk);
    check("agg_n2", int'(pos_agg[inst]), 1);
    @(negedge clk);
    check("agg_n3", int'(pos_agg[inst]), 0);
    in_v[inst] = 5'b00000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;

    vecs[0]  = '{0, 5'b01000, 644, 512};
    vecs[1]  = '{0, 5'b01100, 644, 512};
    vecs[2]  = '{0, 5'b00010, 644, 516};
    vecs[3]  = '{0, 5'b00001, 644, 512};
    vecs[4]  = '{0, 5'b00100, 640, 512};
    vecs[5]  = '{0, 5'b00011, 640, 512};
    vecs[6]  = '{0, 5'b00000, 640, 512};
    vecs[7]  = '{0, 5'b01010, 644, 516};
    vecs[8]  = '{1, 5'b01000,   2, 512};
    vecs[9]  = '{1, 5'b00100, 1278, 512};
    vecs[10] = '{2, 5'b00001, 640,  50};
    vecs[11] = '{2, 5'b00001, 640,  50};
    vecs[12] = '{2, 5'b00010, 640,  54};
    vecs[13] = '{3, 5'b10101, 644, 973};
    vecs[14] = '{3, 5'b11010, 648, 969};
    vecs[15] = '{3, 5'b11111, 652, 965};
    vecs[16] = '{3, 5'b00010, 652, 969};
    vecs[17] = '{3, 5'b10000, 656, 965};

    rst_n      = 1'b0;
    frame_tick = 1'b0;
    for (int i = 0; i < 4; i++) in_v[i] = 5'b00000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_x0", int'(x_pos[0]), 640);
    check("rst_y0", int'(y_pos[0]), 512);
    check("rst_agg0", int'(pos_agg[0]), 0);
    check("rst_x1", int'(x_pos[1]), 1278);
    check("rst_y2", int'(y_pos[2]), 52);
    check("rst_y3", int'(y_pos[3]), 971);

    for (int v = 0; v < 18; v++) begin
      do_tick(vecs[v].inst, vecs[v].inv, vecs[v].ex, vecs[v].ey);
    end

    // Ticks in back-to-back cycles: only the first is honoured.
    in_v[0] = 5'b01000;
    repeat (3) @(negedge clk);
    exp_q.push_back('{0, 648, 516});
    frame_tick = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        frame_tick = 1'b0;
        check("coll_agg_n2", int'(pos_agg[0]), 1);
      end
      if (pos_agg[0]) pulses++;
    end
    check("coll_pulses", pulses, 1);
    check("coll_x", int'(x_pos[0]), 648);
    in_v[0] = 5'b00000;

    // Reset during CALCOLO aborts the update and restores outputs without a clock edge.
    in_v[0] = 5'b01000;
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_x0_async", int'(x_pos[0]), 640);
    check("abort_y0_async", int'(y_pos[0]), 512);
    check("abort_y3_async", int'(y_pos[3]), 971);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (pos_agg[0]) pulses++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (pos_agg[0]) pulses++;
    end
    check("abort_pulses", pulses, 0);
    check("abort_x0", int'(x_pos[0]), 640);
    in_v[0] = 5'b00000;

    check("sb_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
